// File: rtl/coef_bank_seq.sv
// coef_bank_seq
//   Double-buffered coefficient bank for a cascade of NUM_BANDS IIR sections.
//   The host fills a shadow bank one word at a time. A commit copies the whole
//   shadow bank into the active bank in a single cycle, and only while the
//   readout is idle. Each frame strobe streams the active bank out, one word
//   per cycle: band 0 first, and within each band b0..bN then a1..aN.
//
// Ports
//   ic_clk, ic_rst_n             clock, async active-low reset (deassert synced)
//   id_wr_data/addr, ic_wr_valid host write into the shadow bank
//   oc_wr_ready                  low while a commit is pending (shadow frozen)
//   oc_wr_err                    pulse: the last accepted write was out of range
//   ic_commit, oc_commit_pend    commit request / commit waiting for idle
//   ic_frame                     start a readout of the active bank
//   od_coef_out, oc_coef_val     streamed coefficient and its valid
//   oc_coef_is_a/idx, oc_band_idx tag of the streamed coefficient
//   oc_done                      coincident with the last word of a frame
//   oc_overrun                   pulse: a frame strobe arrived during readout
module coef_bank_seq #(
    parameter int  WIDTH     = 27,
    parameter int  ORDER_IIR = 2,
    parameter int  NUM_BANDS = 4,
    localparam int NCOEF     = 2*ORDER_IIR + 1,
    localparam int DEPTH     = NUM_BANDS*NCOEF,
    localparam int AW        = $clog2(DEPTH),
    localparam int BW        = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1,
    localparam int CW        = (ORDER_IIR > 0) ? $clog2(ORDER_IIR + 1) : 1
) (
    input  logic             ic_clk,
    input  logic             ic_rst_n,
    input  logic [WIDTH-1:0] id_wr_data,
    input  logic [AW-1:0]    id_wr_addr,
    input  logic             ic_wr_valid,
    output logic             oc_wr_ready,
    output logic             oc_wr_err,
    input  logic             ic_commit,
    output logic             oc_commit_pend,
    input  logic             ic_frame,
    output logic [WIDTH-1:0] od_coef_out,
    output logic             oc_coef_val,
    output logic             oc_coef_is_a,
    output logic [CW-1:0]    oc_coef_idx,
    output logic [BW-1:0]    oc_band_idx,
    output logic             oc_done,
    output logic             oc_overrun
);

    localparam int                KW     = $clog2(NCOEF);
    localparam logic [AW:0]       DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]     LAST   = AW'(DEPTH - 1);
    localparam logic [KW-1:0]     KLAST  = KW'(NCOEF - 1);
    localparam logic [KW-1:0]     K_ORD  = KW'(ORDER_IIR);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic             val;
        logic             done;
        logic             is_a;
        logic [CW-1:0]    idx;
        logic [BW-1:0]    band;
        logic [WIDTH-1:0] coef;
    } coef_rsp_t;

    // Reset asserts asynchronously, releases two edges after ic_rst_n rises.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) rst_sync <= '0;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    logic [DEPTH-1:0][WIDTH-1:0] shadow, active;
    state_t                      state, state_nxt;
    logic [AW-1:0]               rd_idx, idx_nxt;
    logic [BW-1:0]               rd_band, band_nxt;
    logic [KW-1:0]               rd_k, k_nxt;
    logic                        commit_pend, frame_pend, frame_pend_nxt;
    logic                        wr_err_q, overrun_q;
    coef_rsp_t                   rsp_q, rsp_d;
    logic                        wr_acc, addr_ok, swap, emit, done_nxt, a_nxt;

    assign wr_acc  = ic_wr_valid && !commit_pend;
    assign addr_ok = {1'b0, id_wr_addr} < DEPTH_W;
    // Swap only in IDLE, so a frame in flight always sees one consistent bank.
    assign swap    = (state == IDLE) && commit_pend;

    always_comb begin
        state_nxt      = state;
        idx_nxt        = rd_idx;
        band_nxt       = rd_band;
        k_nxt          = rd_k;
        frame_pend_nxt = frame_pend;
        emit           = 1'b0;
        done_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (ic_frame || frame_pend) begin
                    if (swap) begin
                        // Hold the frame one cycle so it reads the new bank.
                        frame_pend_nxt = 1'b1;
                    end else begin
                        state_nxt      = RUN;
                        frame_pend_nxt = 1'b0;
                        emit           = 1'b1;
                        idx_nxt        = '0;
                        band_nxt       = '0;
                        k_nxt          = '0;
                    end
                end
            end
            RUN: begin
                // RUN spans exactly the cycles where a word is on the output.
                if (rd_idx == LAST) begin
                    state_nxt = IDLE;
                end else begin
                    emit    = 1'b1;
                    idx_nxt = rd_idx + AW'(1);
                    if (rd_k == KLAST) begin
                        k_nxt    = '0;
                        band_nxt = rd_band + BW'(1);
                    end else begin
                        k_nxt = rd_k + KW'(1);
                    end
                    done_nxt = (idx_nxt == LAST);
                end
            end
            default: state_nxt = IDLE;
        endcase

        a_nxt = k_nxt > K_ORD;
        rsp_d = '0;
        if (emit) begin
            rsp_d.val  = 1'b1;
            rsp_d.done = done_nxt;
            rsp_d.is_a = a_nxt;
            rsp_d.idx  = a_nxt ? CW'(k_nxt - K_ORD) : CW'(k_nxt);
            rsp_d.band = band_nxt;
            rsp_d.coef = active[idx_nxt];
        end
    end

    always_ff @(posedge ic_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_idx      <= '0;
            rd_band     <= '0;
            rd_k        <= '0;
            frame_pend  <= 1'b0;
            commit_pend <= 1'b0;
            wr_err_q    <= 1'b0;
            overrun_q   <= 1'b0;
            rsp_q       <= '0;
            shadow      <= '0;
            active      <= '0;
        end else begin
            state      <= state_nxt;
            rd_idx     <= idx_nxt;
            rd_band    <= band_nxt;
            rd_k       <= k_nxt;
            frame_pend <= frame_pend_nxt;
            rsp_q      <= rsp_d;
            wr_err_q   <= wr_acc && !addr_ok;
            overrun_q  <= (state == RUN) && ic_frame;
            if (swap)           commit_pend <= 1'b0;
            else if (ic_commit) commit_pend <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_acc && addr_ok && id_wr_addr == AW'(i))
                    shadow[i] <= id_wr_data;
            end
            // Shadow is frozen while commit_pend is set, so no write races this copy.
            if (swap) active <= shadow;
        end
    end

    assign oc_wr_ready    = !commit_pend;
    assign oc_commit_pend = commit_pend;
    assign oc_wr_err      = wr_err_q;
    assign oc_overrun     = overrun_q;
    assign oc_coef_val    = rsp_q.val;
    assign oc_done        = rsp_q.done;
    assign oc_coef_is_a   = rsp_q.is_a;
    assign oc_coef_idx    = rsp_q.idx;
    assign oc_band_idx    = rsp_q.band;
    assign od_coef_out    = rsp_q.coef;

endmodule

// File: tb/tb_coef_bank_seq.sv
// Directed bench for coef_bank_seq with NUM_BANDS=2, ORDER_IIR=2 (DEPTH=10).
// Inputs change and outputs are sampled on the falling edge.
module tb_coef_bank_seq;

    localparam int W   = 27;
    localparam int ORD = 2;
    localparam int NB  = 2;
    localparam int NC  = 2*ORD + 1;
    localparam int D   = NB*NC;

    logic          ic_clk = 1'b0;
    logic          ic_rst_n = 1'b1;
    logic [W-1:0]  id_wr_data = '0;
    logic [3:0]    id_wr_addr = '0;
    logic          ic_wr_valid = 1'b0;
    logic          oc_wr_ready, oc_wr_err;
    logic          ic_commit = 1'b0;
    logic          oc_commit_pend;
    logic          ic_frame = 1'b0;
    logic [W-1:0]  od_coef_out;
    logic          oc_coef_val, oc_coef_is_a, oc_done, oc_overrun;
    logic [1:0]    oc_coef_idx;
    logic [0:0]    oc_band_idx;

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0] shd [D];
    logic [W-1:0] act [D];
    logic [32:0]  got, exp;

    always #5 ic_clk = ~ic_clk;

    coef_bank_seq #(.WIDTH(W), .ORDER_IIR(ORD), .NUM_BANDS(NB)) dut (
        .ic_clk(ic_clk), .ic_rst_n(ic_rst_n),
        .id_wr_data(id_wr_data), .id_wr_addr(id_wr_addr), .ic_wr_valid(ic_wr_valid),
        .oc_wr_ready(oc_wr_ready), .oc_wr_err(oc_wr_err),
        .ic_commit(ic_commit), .oc_commit_pend(oc_commit_pend),
        .ic_frame(ic_frame), .od_coef_out(od_coef_out), .oc_coef_val(oc_coef_val),
        .oc_coef_is_a(oc_coef_is_a), .oc_coef_idx(oc_coef_idx),
        .oc_band_idx(oc_band_idx), .oc_done(oc_done), .oc_overrun(oc_overrun)
    );

    // {val, done, is_a, idx, band, coef} expected for stream word i.
    function automatic logic [32:0] exp_word(input int i);
        int   k;
        logic a;
        k = i % NC;
        a = k > ORD;
        return {1'b1, (i == D-1), a, 2'(a ? k - ORD : k), 1'(i / NC), act[i]};
    endfunction

    task automatic tick();
        @(negedge ic_clk);
    endtask

    task automatic do_write(input int a, input logic [W-1:0] d);
        ic_wr_valid = 1'b1;
        id_wr_addr  = 4'(a);
        id_wr_data  = d;
        tick();
        ic_wr_valid = 1'b0;
        if (a < D) shd[a] = d;
    endtask

    task automatic sample();
        got = {oc_coef_val, oc_done, oc_coef_is_a, oc_coef_idx, oc_band_idx, od_coef_out};
    endtask

    task automatic test_reset();
        for (int i = 0; i < D; i++) begin shd[i] = '0; act[i] = '0; end
        #2 ic_rst_n = 1'b0;
        tick(); tick();
        sample();
        n_chk++;
        if (got !== 33'h0 || oc_wr_err !== 1'b0 || oc_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got=%h err=%b ovr=%b exp all 0", got, oc_wr_err, oc_overrun);
        end
        n_chk++;
        if (oc_wr_ready !== 1'b1 || oc_commit_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: rdy=%b pend=%b exp rdy=1 pend=0", oc_wr_ready, oc_commit_pend);
        end
        ic_rst_n = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic test_zero_frame();
        ic_frame = 1'b1; tick(); ic_frame = 1'b0;
        for (int i = 0; i < D; i++) begin
            sample(); exp = exp_word(i);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL zero_frame[%0d]: got=%h exp=%h", i, got, exp);
            end
            tick();
        end
        sample();
        n_chk++;
        if (got !== 33'h0) begin
            n_fail++;
            $display("FAIL zero_frame_idle: got=%h exp=0", got);
        end
    endtask

    task automatic test_write_commit();
        for (int k = 0; k < D; k++) do_write(k, W'(100 + k));
        ic_commit = 1'b1; tick(); ic_commit = 1'b0;
        n_chk++;
        if (oc_commit_pend !== 1'b1 || oc_wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_pend_set: pend=%b rdy=%b exp 1/0", oc_commit_pend, oc_wr_ready);
        end
        tick();
        n_chk++;
        if (oc_commit_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_pend_clr: pend=%b exp 0", oc_commit_pend);
        end
        for (int i = 0; i < D; i++) act[i] = shd[i];
        tick();
        ic_frame = 1'b1; tick(); ic_frame = 1'b0;
        for (int i = 0; i < D; i++) begin
            sample(); exp = exp_word(i);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL stream_100[%0d]: got=%h exp=%h", i, got, exp);
            end
            tick();
        end
        do_write(3, W'(-5));
        ic_commit = 1'b1; tick(); ic_commit = 1'b0;
        tick();
        for (int i = 0; i < D; i++) act[i] = shd[i];
        ic_frame = 1'b1; tick(); ic_frame = 1'b0;
        for (int i = 0; i < D; i++) begin
            sample(); exp = exp_word(i);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL stream_neg[%0d]: got=%h exp=%h", i, got, exp);
            end
            if (i == 3) begin
                n_chk++;
                if ($signed(od_coef_out) != -5) begin
                    n_fail++;
                    $display("FAIL neg_sign: got=%0d exp=-5", $signed(od_coef_out));
                end
            end
            tick();
        end
    endtask

    task automatic test_commit_mid_frame();
        for (int k = 0; k < D; k++) do_write(k, W'(200 + k));
        ic_frame = 1'b1; tick(); ic_frame = 1'b0;
        for (int i = 0; i < D; i++) begin
            sample(); exp = exp_word(i);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mid_old[%0d]: got=%h exp=%h", i, got, exp);
            end
            ic_commit = (i == 3);
            tick();
        end
        ic_commit = 1'b0;
        n_chk++;
        if (oc_commit_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pend_held: pend=%b exp 1", oc_commit_pend);
        end
        tick();
        n_chk++;
        if (oc_commit_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_swap: pend=%b exp 0", oc_commit_pend);
        end
        for (int i = 0; i < D; i++) act[i] = shd[i];
        ic_frame = 1'b1; tick(); ic_frame = 1'b0;
        for (int i = 0; i < D; i++) begin
            sample(); exp = exp_word(i);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL mid_new[%0d]: got=%h exp=%h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_frame_on_swap();
        do_write(0, W'(-1));
        do_write(9, W'(300));
        ic_commit = 1'b1; tick(); ic_commit = 1'b0;
        ic_frame = 1'b1; tick(); ic_frame = 1'b0;
        for (int i = 0; i < D; i++) act[i] = shd[i];
        sample();
        n_chk++;
        if (got !== 33'h0) begin
            n_fail++;
            $display("FAIL swap_frame_wait: got=%h exp=0", got);
        end
        tick();
        for (int i = 0; i < D; i++) begin
            sample(); exp = exp_word(i);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL swap_frame[%0d]: got=%h exp=%h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_wr_blocked();
        do_write(5, W'(77));
        n_chk++;
        if (oc_wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL good_wr_err: err=%b exp 0", oc_wr_err);
        end
        ic_commit = 1'b1; tick(); ic_commit = 1'b0;
        n_chk++;
        if (oc_wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL blocked_ready: rdy=%b exp 0", oc_wr_ready);
        end
        ic_wr_valid = 1'b1; id_wr_addr = 4'd6; id_wr_data = W'(999);
        tick();
        ic_wr_valid = 1'b0;
        for (int i = 0; i < D; i++) act[i] = shd[i];
        n_chk++;
        if (oc_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_back: rdy=%b exp 1", oc_wr_ready);
        end
        do_write(12, W'(555));
        n_chk++;
        if (oc_wr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_err_pulse: err=%b exp 1", oc_wr_err);
        end
        tick();
        n_chk++;
        if (oc_wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_err_clear: err=%b exp 0", oc_wr_err);
        end
        ic_commit = 1'b1; tick(); ic_commit = 1'b0;
        tick(); tick();
        for (int i = 0; i < D; i++) act[i] = shd[i];
        ic_frame = 1'b1; tick(); ic_frame = 1'b0;
        for (int i = 0; i < D; i++) begin
            sample(); exp = exp_word(i);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL blocked_bank[%0d]: got=%h exp=%h", i, got, exp);
            end
            tick();
        end
    endtask

    task automatic test_overrun_reset();
        ic_frame = 1'b1; tick(); ic_frame = 1'b0;
        for (int i = 0; i < D; i++) begin
            sample(); exp = exp_word(i);
            n_chk++;
            if (got !== exp || oc_overrun !== (i == 3)) begin
                n_fail++;
                $display("FAIL overrun[%0d]: got=%h ovr=%b exp=%h ovr=%b", i, got, oc_overrun, exp, (i == 3));
            end
            ic_frame = (i == 2);
            tick();
        end
        ic_frame = 1'b0;
        sample();
        n_chk++;
        if (got !== 33'h0) begin
            n_fail++;
            $display("FAIL overrun_no_restart: got=%h exp=0", got);
        end
        ic_frame = 1'b1; tick(); ic_frame = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample(); exp = exp_word(i);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL pre_rst[%0d]: got=%h exp=%h", i, got, exp);
            end
            if (i < 4) tick();
        end
        ic_rst_n = 1'b0;
        #1;
        sample();
        n_chk++;
        if (got !== 33'h0 || oc_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_in_run: got=%h rdy=%b exp 0/1", got, oc_wr_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (oc_done !== 1'b0 || oc_coef_val !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_no_done[%0d]: done=%b val=%b exp 0", i, oc_done, oc_coef_val);
            end
        end
        ic_rst_n = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < D; i++) begin shd[i] = '0; act[i] = '0; end
        ic_frame = 1'b1; tick(); ic_frame = 1'b0;
        for (int i = 0; i < D; i++) begin
            sample(); exp = exp_word(i);
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL post_rst_bank[%0d]: got=%h exp=%h", i, got, exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_write_commit();
        test_commit_mid_frame();
        test_frame_on_swap();
        test_wr_blocked();
        test_overrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
